exp_attn_pipe: RTL and testbench
================================

// Module: exp_attn_pipe
// PURPOSE
//  Pipelined log-to-linear converter for the FM operator datapath, time-shared across channels.
//  Input: log-domain attenuation (octave shift + fractional index) plus sign.
//  Output: signed linear sample, computed as ((exp_tab[frac] | 2^MANT_W) << 1) >> shift.
//  Each sample carries a channel tag. The block sits between the log-sin/envelope adder and the channel mixer.
// PARAMETERS
//  FRAC_W   8   fractional index bits; exp table depth = 2^FRAC_W
//  MANT_W   10  table entry width; derived OUT_W = MANT_W+3 (signed output)
//  SHIFT_W  5   octave shift bits; derived ATT_W = SHIFT_W+FRAC_W
//  TAG_W    5   channel tag width, carried alongside the sample
//  NEG_MODE 0   negative encoding: 0 = one's complement (~mag), 1 = two's complement (-mag)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      input sample valid
//  in_ready   out  1      block accepts input this cycle
//  in_atten   in   ATT_W  [ATT_W-1:FRAC_W] = shift, [FRAC_W-1:0] = table index
//  in_sign    in   1      1 = negative half-wave
//  in_mute    in   1      force output to exactly 0
//  in_tag     in   TAG_W  channel id
//  out_valid  out  1      output sample valid
//  out_ready  in   1      downstream accepts output
//  out_sample out  OUT_W  signed linear sample
//  out_tag    out  TAG_W  channel id of out_sample
// BEHAVIOUR
//  - Exp table
//    - Built at elaboration by a constant function: tab[i] = round((2^((M-1-i)/M) - 1) * 2^MANT_W), M = 2^FRAC_W.
//    - Defaults give tab[0]=0x3FA and tab[M-1]=0x000.
//    - Implemented as distributed ROM.
//  - Pipeline: 3 register stages, latency exactly 3 cycles from accept to out_valid when not stalled.
//    - S1: registered lookup; mant = {1'b1, tab[idx]}; latch shift, sign, mute, tag.
//    - S2: mag = (mant << 1) >> shift. Width MANT_W+2 unsigned. If shift >= MANT_W+2, mag = 0.
//    - S3: mute -> 0. Otherwise sign=0 -> +mag; sign=1 -> ~mag (NEG_MODE 0) or -mag (NEG_MODE 1).
//  - Handshake
//    - stall = out_valid & ~out_ready.
//    - in_ready = ~stall, combinational; no combinational path from in_valid.
//    - Accept occurs when in_valid & in_ready.
//    - On stall, all stages hold: out_sample and out_tag are stable and nothing is dropped or duplicated.
//    - When not stalled, every stage advances each cycle. Bubbles propagate as per-stage valid = 0.
//    - Full throughput: 1 sample/cycle while out_ready stays high.
//  - Reset
//    - While reset_n is low: all stage valids, out_valid, out_sample and out_tag are 0; in_ready is 1.
//    - Reset mid-stream discards all in-flight samples.
//    - The first accept after reset_n rises yields out_valid 3 cycles later.
//  - Edge cases
//    - Negative zero under NEG_MODE 0 (sign=1, mag=0) outputs -1. This is intentional, for FM compatibility.
//    - Mute overrides sign in both modes.
//    - The tag is never altered and leaves in input order.
// TESTING
//  1. atten=0x000, sign=0 -> out_sample=+4084 (0xFF4) after 3 cycles, tag echoed.
//  2. atten=0x0FF -> 2048; atten=0x100 -> 2042; atten=0xB00 (shift 11) -> 1; atten=0xC00 -> 0.
//  3. atten=0, sign=1 -> -4085 (NEG_MODE 0) / -4084 (NEG_MODE 1); atten=0xC00, sign=1 -> -1 / 0.
//  4. in_mute=1, sign=1, atten=0 -> exactly 0 in both modes.
//  5. Back-to-back stream, tags 0..31, with out_ready toggled randomly.
//     -> Outputs in order, no loss or duplication.
//     -> Outputs held stable while stalled.
//     -> Throughput is 1/cycle whenever out_ready stays high.
//  6. reset_n pulled low with 3 samples in flight -> out_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/exp_attn_pipe.sv
// exp_attn_pipe: three-stage log-to-linear converter for the FM operator datapath.
// A log-domain attenuation (octave shift + fractional table index) plus a sign
// is turned into a signed linear sample:
//   ((exp_tab[frac] | 2^MANT_W) << 1) >> shift, then negated for the negative half-wave.
// Each sample carries a channel tag that passes through untouched and in order.
//
// Handshake (both sides use strict valid/ready): a transfer happens on a rising
// clock edge where valid and ready are both high. A producer holds valid and its
// payload steady until the transfer happens. Here in_ready = ~(out_valid & ~out_ready),
// so in_ready depends only on registered state and on out_ready, never on in_valid.
// While the output is stalled every stage holds. Otherwise every stage advances
// each cycle, and empty slots travel down the pipe as per-stage valid = 0.
module exp_attn_pipe #(
  parameter  int FRAC_W   = 8,
  parameter  int MANT_W   = 10,
  parameter  int SHIFT_W  = 5,
  parameter  int TAG_W    = 5,
  parameter  int NEG_MODE = 0,
  localparam int OUT_W    = MANT_W + 3,
  localparam int ATT_W    = SHIFT_W + FRAC_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ATT_W-1:0]        in_atten,
  input  logic                    in_sign,
  input  logic                    in_mute,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sample,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int M     = 1 << FRAC_W;
  localparam int MAG_W = MANT_W + 2;

  // Exp table, built at elaboration:
  //   tab[i] = round((2^((M-1-i)/M) - 1) * 2^MANT_W).
  // Index 0 is the loudest entry and index M-1 is the quietest (0).
  function automatic logic [M*MANT_W-1:0] build_exp_tab();
    logic [M*MANT_W-1:0] t;
    real                 e;
    integer              v;
    t = '0;
    for (int i = 0; i < M; i++) begin
      e = (2.0 ** ($itor(M - 1 - i) / $itor(M)) - 1.0) * $itor(1 << MANT_W);
      v = $rtoi(e + 0.5);
      t[i*MANT_W +: MANT_W] = v[MANT_W-1:0];
    end
    return t;
  endfunction

  localparam logic [M*MANT_W-1:0] EXP_TAB = build_exp_tab();

  // Small ROM view of the table; it maps onto LUTs.
  logic [MANT_W-1:0] exp_rom [M];
  for (genvar g = 0; g < M; g++) begin : g_rom
    assign exp_rom[g] = EXP_TAB[g*MANT_W +: MANT_W];
  end

  // Flow control
  logic stall;
  logic advance;

  // Stage 1: lookup result plus side-band
  logic               s1_valid;
  logic [MANT_W:0]    s1_mant;
  logic [SHIFT_W-1:0] s1_shift;
  logic               s1_sign;
  logic               s1_mute;
  logic [TAG_W-1:0]   s1_tag;

  // Stage 2: unsigned magnitude
  logic               s2_valid;
  logic [MAG_W-1:0]   s2_mag;
  logic               s2_sign;
  logic               s2_mute;
  logic [TAG_W-1:0]   s2_tag;

  // Stage 3: signed sample, drives the outputs directly
  logic                    s3_valid;
  logic signed [OUT_W-1:0] s3_sample;
  logic [TAG_W-1:0]        s3_tag;

  // Combinational next values
  logic [MAG_W-1:0]        mant_x2;
  logic [MAG_W-1:0]        mag_next;
  logic [OUT_W-1:0]        mag_ext;
  logic signed [OUT_W-1:0] sample_next;

  // Stall only when a sample sits at the output and downstream refuses it.
  assign stall    = s3_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // Stage 1 register: table lookup, and latch the shift, sign, mute and tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_shift <= '0;
      s1_sign  <= 1'b0;
      s1_mute  <= 1'b0;
      s1_tag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_mant  <= {1'b1, exp_rom[in_atten[FRAC_W-1:0]]};
      s1_shift <= in_atten[ATT_W-1:FRAC_W];
      s1_sign  <= in_sign;
      s1_mute  <= in_mute;
      s1_tag   <= in_tag;
    end
  end

  // Octave shift. Large shifts are clamped to zero explicitly so the result
  // does not depend on how a shift wider than the operand is handled.
  always_comb begin
    mant_x2 = {s1_mant, 1'b0};
    if (int'(s1_shift) >= MAG_W) begin
      mag_next = '0;
    end else begin
      mag_next = mant_x2 >> s1_shift;
    end
  end

  // Stage 2 register: magnitude plus side-band.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_sign  <= 1'b0;
      s2_mute  <= 1'b0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_mag   <= mag_next;
      s2_sign  <= s1_sign;
      s2_mute  <= s1_mute;
      s2_tag   <= s1_tag;
    end
  end

  // Sign application. Mute wins over the sign. In one's-complement mode a zero
  // magnitude on the negative half-wave gives -1, which matches FM chip behaviour.
  always_comb begin
    mag_ext = {1'b0, s2_mag};
    if (s2_mute) begin
      sample_next = '0;
    end else if (s2_sign) begin
      if (NEG_MODE != 0) begin
        sample_next = $signed(~mag_ext + OUT_W'(1));
      end else begin
        sample_next = $signed(~mag_ext);
      end
    end else begin
      sample_next = $signed(mag_ext);
    end
  end

  // Stage 3 register: final signed sample and tag, held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid  <= 1'b0;
      s3_sample <= '0;
      s3_tag    <= '0;
    end else if (advance) begin
      s3_valid  <= s2_valid;
      s3_sample <= sample_next;
      s3_tag    <= s2_tag;
    end
  end

  assign out_valid  = s3_valid;
  assign out_sample = s3_sample;
  assign out_tag    = s3_tag;

endmodule

// File: tb/tb_exp_attn_pipe.sv
// tb_exp_attn_pipe: directed checks of exp_attn_pipe in both negative-encoding
// modes (two instances share the stimulus), a randomly back-pressured tagged
// stream, a full-throughput burst, and reset while samples are in flight.
module tb_exp_attn_pipe;

  localparam int OUT_W = 13;
  localparam int ATT_W = 13;
  localparam int TAG_W = 5;
  localparam int QW    = TAG_W + 2 * OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             in_valid;
  logic [ATT_W-1:0] in_atten;
  logic             in_sign;
  logic             in_mute;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready0, in_ready1;
  logic             out_valid0, out_valid1;
  logic [OUT_W-1:0] out_sample0, out_sample1;
  logic [TAG_W-1:0] out_tag0, out_tag1;

  exp_attn_pipe #(.NEG_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_atten(in_atten), .in_sign(in_sign), .in_mute(in_mute), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_sample(out_sample0), .out_tag(out_tag0)
  );

  exp_attn_pipe #(.NEG_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_atten(in_atten), .in_sign(in_sign), .in_mute(in_mute), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_sample(out_sample1), .out_tag(out_tag1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [QW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One isolated sample; checks the exact 3-cycle latency and both modes' values.
  task automatic run_vec(input logic [ATT_W-1:0] atten, input logic sign, input logic mute,
                         input logic [TAG_W-1:0] tag, input int exp0, input int exp1);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_atten  = atten;
    in_sign   = sign;
    in_mute   = mute;
    in_tag    = tag;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_c1_valid", 32'(out_valid0), 32'd0);
    @(negedge clk);
    chk("lat_c2_valid", 32'(out_valid0), 32'd0);
    @(negedge clk);
    chk("lat_c3_valid0", 32'(out_valid0), 32'd1);
    chk("lat_c3_valid1", 32'(out_valid1), 32'd1);
    chk("sample_neg0", 32'($signed(out_sample0)), 32'(exp0));
    chk("sample_neg1", 32'($signed(out_sample1)), 32'(exp1));
    chk("tag_neg0", 32'(out_tag0), 32'(tag));
    chk("tag_neg1", 32'(out_tag1), 32'(tag));
    @(negedge clk);
    chk("lat_c4_valid", 32'(out_valid0), 32'd0);
  endtask

  // Drives the stream fields for sample n: atten index 0xFF gives mantissa 2^MANT_W.
  task automatic drive_stream(input int n);
    int sh;
    sh       = n % 14;
    in_atten = {5'(sh), 8'hFF};
    in_sign  = (n % 2) == 1;
    in_mute  = (n % 7) == 5;
    in_tag   = 5'(n);
  endtask

  function automatic logic [QW-1:0] stream_expect(input int n);
    int sh, mag, e0, e1;
    logic [OUT_W-1:0] f0, f1;
    sh  = n % 14;
    mag = (sh >= 12) ? 0 : (2048 >> sh);
    if ((n % 7) == 5) begin
      e0 = 0; e1 = 0;
    end else if ((n % 2) == 1) begin
      e0 = -mag - 1; e1 = -mag;
    end else begin
      e0 = mag; e1 = mag;
    end
    f0 = OUT_W'(e0);
    f1 = OUT_W'(e1);
    return {5'(n), f0, f1};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [QW-1:0]    e;
    logic             hold;
    logic             prev_stall;
    logic [OUT_W-1:0] prev_s0;
    logic [TAG_W-1:0] prev_tag;
    int sent, recv, cyc, first, nvalid;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_atten  = '0;
    in_sign   = 1'b0;
    in_mute   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_sample", 32'(out_sample0), 32'd0);
    chk("rst_out_tag", 32'(out_tag0), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors (expected values worked out by hand)
    run_vec(13'h000, 1'b0, 1'b0, 5'd1,  4084,  4084);
    run_vec(13'h0FF, 1'b0, 1'b0, 5'd2,  2048,  2048);
    run_vec(13'h100, 1'b0, 1'b0, 5'd3,  2042,  2042);
    run_vec(13'hB00, 1'b0, 1'b0, 5'd4,  1,     1);
    run_vec(13'hC00, 1'b0, 1'b0, 5'd5,  0,     0);
    run_vec(13'h000, 1'b1, 1'b0, 5'd6,  -4085, -4084);
    run_vec(13'hC00, 1'b1, 1'b0, 5'd7,  -1,    0);
    run_vec(13'h000, 1'b1, 1'b1, 5'd8,  0,     0);
    run_vec(13'h0FF, 1'b0, 1'b1, 5'd9,  0,     0);
    run_vec(13'h1FFF, 1'b1, 1'b0, 5'd10, -1,   0);
    run_vec(13'h2FF, 1'b0, 1'b0, 5'd11, 512,   512);
    run_vec(13'h180, 1'b1, 1'b0, 5'd12, -1445, -1444);

    // Tagged stream 0..31 with random bubbles and random back-pressure
    hold = 1'b0; prev_stall = 1'b0; prev_s0 = '0; prev_tag = '0;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 32 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        if (sent < 32 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          drive_stream(sent);
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (prev_stall) begin
        chk("stall_hold_sample", 32'(out_sample0), 32'(prev_s0));
        chk("stall_hold_tag", 32'(out_tag0), 32'(prev_tag));
        chk("stall_hold_valid", 32'(out_valid0), 32'd1);
      end
      if (out_valid0 && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_output", 32'(out_tag0), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_tag", 32'(out_tag0), 32'(e[QW-1 -: TAG_W]));
          chk("stream_sample0", 32'(out_sample0), 32'(e[2*OUT_W-1 -: OUT_W]));
          chk("stream_sample1", 32'(out_sample1), 32'(e[OUT_W-1:0]));
        end
        recv++;
      end
      if (in_valid && in_ready0) begin
        exp_q.push_back(stream_expect(sent));
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      prev_stall = out_valid0 && !out_ready;
      prev_s0    = out_sample0;
      prev_tag   = out_tag0;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_received", 32'(recv), 32'd32);
    chk("stream_sent", 32'(sent), 32'd32);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    // Full-throughput burst: 16 back-to-back samples with out_ready held high
    first = -1; nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 16);
      in_atten  = 13'h0FF;
      in_sign   = 1'b0;
      in_mute   = 1'b0;
      in_tag    = 5'(c);
      #1;
      if (out_valid0) begin
        if (first < 0) first = c;
        chk("burst_tag", 32'(out_tag0), 32'(nvalid));
        nvalid++;
      end
    end
    chk("burst_first_cycle", 32'(first), 32'd3);
    chk("burst_count", 32'(nvalid), 32'd16);

    // Reset with samples in flight
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_atten = 13'h000;
      in_sign  = 1'b0;
      in_mute  = 1'b0;
      in_tag   = 5'(20 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(out_valid0), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid0", 32'(out_valid0), 32'd0);
    chk("midrst_out_valid1", 32'(out_valid1), 32'd0);
    chk("midrst_in_ready", 32'(in_ready0), 32'd1);
    chk("midrst_out_sample", 32'(out_sample0), 32'd0);
    chk("midrst_out_tag", 32'(out_tag0), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid0 | out_valid1), 32'd0);
    end
    run_vec(13'h100, 1'b1, 1'b0, 5'd30, -2043, -2042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
